// File: rtl/wb_writer.sv
// Writeback stage: registers MEM/WB, formats load data, picks the writeback source,
// and merges multiply/divide results through a one-entry buffer with bounded starvation.
module wb_writer #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_wb_sel,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_load_data,
  input  logic [2:0]  mem_load_type,
  input  logic [1:0]  mem_addr_lo,
  input  logic [31:0] mem_pc_plus8,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        wb_stall,
  output logic [4:0]  wrt_addr,
  output logic [31:0] wrt_data,
  output logic        wrt_ctrl
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // MDU handshake: a result transfers on a cycle where mdu_valid and mdu_ready are
  // both high; mdu_ready stays low while the buffer holds a result or rst is high.

  logic        wrt_ctrl_q, wrt_ctrl_d;
  logic [4:0]  wrt_addr_q, wrt_addr_d;
  logic [31:0] wrt_data_q, wrt_data_d;
  logic        buf_full_q, buf_full_d;
  logic [4:0]  buf_rd_q, buf_rd_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;

  logic [31:0] lane_word;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;
  logic [31:0] wb_data;
  logic        pipe_we;
  logic        pipe_wr;
  logic        drain;
  logic        accept;

  // Selected byte lands in bits [7:0] after shifting by 8*addr_lo.
  assign lane_word = mem_load_data >> {mem_addr_lo, 3'b000};
  assign half_sel  = mem_addr_lo[1] ? mem_load_data[31:16] : mem_load_data[15:0];

  always_comb begin
    load_fmt = mem_load_data;
    case (mem_load_type)
      3'b001:  load_fmt = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b010:  load_fmt = {24'd0, lane_word[7:0]};
      3'b011:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_fmt = {16'd0, half_sel};
      default: load_fmt = mem_load_data;
    endcase
  end

  always_comb begin
    wb_data = mem_alu_result;
    case (mem_wb_sel)
      2'b01:   wb_data = load_fmt;
      2'b10:   wb_data = mem_pc_plus8;
      default: wb_data = mem_alu_result;
    endcase
  end

  assign pipe_we   = mem_valid & mem_reg_write & (mem_rd != 5'd0);
  assign wb_stall  = buf_full_q & (starve_cnt_q >= LIMIT) & !rst;
  assign pipe_wr   = pipe_we & !wb_stall;
  assign drain     = buf_full_q & (wb_stall | !pipe_we);
  assign mdu_ready = !buf_full_q & !rst;
  // Results for r0 complete the handshake but never occupy the buffer.
  assign accept    = mdu_valid & mdu_ready & (mdu_rd != 5'd0);

  always_comb begin
    wrt_ctrl_d   = 1'b0;
    wrt_addr_d   = wrt_addr_q;
    wrt_data_d   = wrt_data_q;
    buf_full_d   = buf_full_q;
    buf_rd_d     = buf_rd_q;
    buf_data_d   = buf_data_q;
    starve_cnt_d = starve_cnt_q;
    if (drain) begin
      wrt_ctrl_d   = 1'b1;
      wrt_addr_d   = buf_rd_q;
      wrt_data_d   = buf_data_q;
      buf_full_d   = 1'b0;
      starve_cnt_d = 4'd0;
    end else if (pipe_wr) begin
      wrt_ctrl_d = 1'b1;
      wrt_addr_d = mem_rd;
      wrt_data_d = wb_data;
      if (buf_full_q && starve_cnt_q != 4'hF) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
    // accept only fires with the buffer empty, so it never collides with a drain.
    if (accept) begin
      buf_full_d = 1'b1;
      buf_rd_d   = mdu_rd;
      buf_data_d = mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrt_ctrl_q   <= 1'b0;
      wrt_addr_q   <= 5'd0;
      wrt_data_q   <= 32'd0;
      buf_full_q   <= 1'b0;
      buf_rd_q     <= 5'd0;
      buf_data_q   <= 32'd0;
      starve_cnt_q <= 4'd0;
    end else begin
      wrt_ctrl_q   <= wrt_ctrl_d;
      wrt_addr_q   <= wrt_addr_d;
      wrt_data_q   <= wrt_data_d;
      buf_full_q   <= buf_full_d;
      buf_rd_q     <= buf_rd_d;
      buf_data_q   <= buf_data_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign wrt_ctrl = wrt_ctrl_q;
  assign wrt_addr = wrt_addr_q;
  assign wrt_data = wrt_data_q;

endmodule

// File: tb/tb_wb_writer.sv
// Bench for wb_writer: directed stimulus with a write scoreboard checked on every
// register-file write, plus cycle-exact checks of stall, ready and idle behaviour.
module tb_wb_writer;

  localparam int unsigned LIM = 3;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_load_data;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_pc_plus8;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        wb_stall;
  logic [4:0]  wrt_addr;
  logic [31:0] wrt_data;
  logic        wrt_ctrl;

  logic [36:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  wb_writer #(.STARVE_LIMIT(LIM)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_rd         (mem_rd),
    .mem_wb_sel     (mem_wb_sel),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .mem_load_type  (mem_load_type),
    .mem_addr_lo    (mem_addr_lo),
    .mem_pc_plus8   (mem_pc_plus8),
    .mdu_valid      (mdu_valid),
    .mdu_rd         (mdu_rd),
    .mdu_data       (mdu_data),
    .mdu_ready      (mdu_ready),
    .wb_stall       (wb_stall),
    .wrt_addr       (wrt_addr),
    .wrt_data       (wrt_data),
    .wrt_ctrl       (wrt_ctrl)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // scoreboard: every register-file write must match the head of exp_q
  always @(negedge clk) begin
    if (wrt_ctrl === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", 64'(wrt_ctrl), 64'd0);
      end else begin
        check("sb_write", 64'({wrt_addr, wrt_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    mem_valid = 1'b0; mem_reg_write = 1'b0; mem_rd = 5'd0; mem_wb_sel = 2'b00;
    mem_alu_result = 32'd0; mem_load_data = 32'd0; mem_load_type = 3'b000;
    mem_addr_lo = 2'd0; mem_pc_plus8 = 32'd0;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
  endtask

  task automatic drive_pipe(input logic [4:0] rd, input logic [1:0] sel,
                            input logic [31:0] alu, input logic [31:0] ld,
                            input logic [2:0] lt, input logic [1:0] alo,
                            input logic [31:0] pc8, input logic [31:0] exp_data);
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = rd; mem_wb_sel = sel;
    mem_alu_result = alu; mem_load_data = ld; mem_load_type = lt;
    mem_addr_lo = alo; mem_pc_plus8 = pc8;
    exp_q.push_back({rd, exp_data});
    step();
  endtask

  initial begin
    int  i;
    bit  stalled;
    bit  exp_stall;

    rst = 1'b1;
    set_idle();
    repeat (2) step();
    @(negedge clk);
    check("rst_wrt_ctrl", 64'(wrt_ctrl), 64'd0);
    check("rst_wrt_addr", 64'(wrt_addr), 64'd0);
    check("rst_wrt_data", 64'(wrt_data), 64'd0);
    check("rst_mdu_ready", 64'(mdu_ready), 64'd0);
    check("rst_wb_stall", 64'(wb_stall), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_mdu_ready", 64'(mdu_ready), 64'd1);
    check("post_rst_wb_stall", 64'(wb_stall), 64'd0);
    step();

    // ALU write with exact latency and idle hold
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd5; mem_wb_sel = 2'b00;
    mem_alu_result = 32'h1234_5678;
    exp_q.push_back({5'd5, 32'h1234_5678});
    @(negedge clk);
    check("alu_before_edge", 64'(wrt_ctrl), 64'd0);
    step();
    set_idle();
    @(negedge clk);
    check("alu_wrt_ctrl", 64'(wrt_ctrl), 64'd1);
    check("alu_wrt_addr", 64'(wrt_addr), 64'd5);
    check("alu_wrt_data", 64'(wrt_data), 64'h1234_5678);
    step();
    @(negedge clk);
    check("idle_wrt_ctrl", 64'(wrt_ctrl), 64'd0);
    check("idle_addr_hold", 64'(wrt_addr), 64'd5);
    check("idle_data_hold", 64'(wrt_data), 64'h1234_5678);
    step();

    // load formatting, back to back
    drive_pipe(5'd1, 2'b01, 32'd0, 32'h80FF_7F01, 3'b001, 2'd2, 32'd0, 32'hFFFF_FFFF);
    drive_pipe(5'd2, 2'b01, 32'd0, 32'h80FF_7F01, 3'b010, 2'd3, 32'd0, 32'h0000_0080);
    drive_pipe(5'd3, 2'b01, 32'd0, 32'h80FF_7F01, 3'b011, 2'd0, 32'd0, 32'h0000_7F01);
    drive_pipe(5'd4, 2'b01, 32'd0, 32'h80FF_7F01, 3'b100, 2'd2, 32'd0, 32'h0000_80FF);
    drive_pipe(5'd6, 2'b01, 32'd0, 32'h80FF_7F01, 3'b001, 2'd3, 32'd0, 32'hFFFF_FF80);
    drive_pipe(5'd7, 2'b01, 32'd0, 32'h80FF_7F01, 3'b011, 2'd3, 32'd0, 32'hFFFF_80FF);
    drive_pipe(5'd8, 2'b01, 32'd0, 32'h80FF_7F01, 3'b100, 2'd1, 32'd0, 32'h0000_7F01);
    drive_pipe(5'd9, 2'b01, 32'd0, 32'h80FF_7F01, 3'b000, 2'd1, 32'd0, 32'h80FF_7F01);
    drive_pipe(5'd10, 2'b01, 32'd0, 32'h80FF_7F01, 3'b111, 2'd2, 32'd0, 32'h80FF_7F01);
    drive_pipe(5'd11, 2'b10, 32'h5, 32'd0, 3'b000, 2'd0, 32'h0000_0400, 32'h0000_0400);
    drive_pipe(5'd12, 2'b11, 32'hABCD_0123, 32'h1, 3'b001, 2'd0, 32'h8, 32'hABCD_0123);
    for (int k = 0; k < 4; k++) begin
      drive_pipe(5'($urandom_range(31, 1)), 2'b00, 32'($urandom), 32'd0, 3'b000, 2'd0,
                 32'd0, 32'd0);
      exp_q[exp_q.size()-1][31:0] = mem_alu_result;
    end
    set_idle();
    repeat (2) step();

    // r0 suppression on both paths
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd0; mem_alu_result = 32'hFFFF;
    mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'h1234;
    step();
    set_idle();
    @(negedge clk);
    check("r0_wrt_ctrl", 64'(wrt_ctrl), 64'd0);
    check("r0_buf_empty_ready", 64'(mdu_ready), 64'd1);
    step();
    @(negedge clk);
    check("r0_no_late_write", 64'(wrt_ctrl), 64'd0);
    step();

    // MDU result drains into a pipeline gap
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'hDEAD_BEEF;
    exp_q.push_back({5'd9, 32'hDEAD_BEEF});
    @(negedge clk);
    check("gap_ready_before", 64'(mdu_ready), 64'd1);
    step();
    set_idle();
    @(negedge clk);
    check("gap_ready_low", 64'(mdu_ready), 64'd0);
    check("gap_not_yet", 64'(wrt_ctrl), 64'd0);
    step();
    @(negedge clk);
    check("gap_ready_back", 64'(mdu_ready), 64'd1);
    check("gap_wrt_ctrl", 64'(wrt_ctrl), 64'd1);
    check("gap_wrt_addr", 64'(wrt_addr), 64'd9);
    step();

    // starvation under continuous pipeline writes
    i = 0;
    stalled = 1'b0;
    while (i < 8) begin
      mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'(10 + i); mem_wb_sel = 2'b00;
      mem_alu_result = 32'hA000_0000 + 32'(i);
      mdu_valid = (i == 2); mdu_rd = 5'd20; mdu_data = 32'hCAFE_0001;
      @(negedge clk);
      exp_stall = (i == 3 + int'(LIM)) && !stalled;
      check("starve_stall", 64'(wb_stall), 64'(exp_stall));
      if (exp_stall) begin
        exp_q.push_back({5'd20, 32'hCAFE_0001});
        stalled = 1'b1;
      end else begin
        exp_q.push_back({mem_rd, mem_alu_result});
        i++;
      end
      step();
    end
    set_idle();
    repeat (2) begin
      @(negedge clk);
      check("starve_stall_after", 64'(wb_stall), 64'd0);
      step();
    end

    // reset with a full buffer and the pipeline writing
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd7; mem_alu_result = 32'h77;
    mdu_valid = 1'b1; mdu_rd = 5'd21; mdu_data = 32'h2121_2121;
    exp_q.push_back({5'd7, 32'h77});
    step();
    mdu_valid = 1'b0; mem_rd = 5'd8; mem_alu_result = 32'h88;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", 64'(mdu_ready), 64'd0);
    check("midrst_stall", 64'(wb_stall), 64'd0);
    step();
    rst = 1'b0;
    set_idle();
    @(negedge clk);
    check("midrst_wrt_ctrl", 64'(wrt_ctrl), 64'd0);
    check("midrst_wrt_addr", 64'(wrt_addr), 64'd0);
    check("midrst_wrt_data", 64'(wrt_data), 64'd0);
    check("midrst_ready_after", 64'(mdu_ready), 64'd1);
    repeat (4) begin
      step();
      @(negedge clk);
      check("midrst_no_write", 64'(wrt_ctrl), 64'd0);
    end
    step();

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
